tick_sync: RTL and testbench

Fast-domain consumer of the divided playback clock. It synchronises a slow level-toggling input, such as the divider's slow output or an external strobe, into `clk` and produces single-cycle rise/fall enables. It also keeps a wrapping beat count, measures the input period and flags a stalled input. Simon playback and sequencer logic run on `clk` gated by `tick_rise`, never on the slow signal as a clock.

---
 rtl/simon_pkg.sv | 14 +
 rtl/sync_edge.sv | 30 +++
 rtl/tick_sync.sv | 136 +++++++++++++
 tb/tb_tick_sync.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared encodings for the Simon playback/sequencer clock-domain logic.
package simon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    STALLED = 2'd3
  } sync_state_e;

  // Two seconds of silence at 100 MHz before the tick source is declared dead.
  localparam int unsigned TICK_TIMEOUT_DEFAULT = 200_000_000;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, with registered
// single-cycle rise/fall strobes. Also used for the button inputs.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~hist_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & hist_q;
    end
  end

endmodule

// File: rtl/tick_sync.sv
// Turns a slow level-toggling input into clk-domain tick enables, with a
// wrapping beat count, period measurement and stall detection.
module tick_sync
  import simon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PERIOD_W    = 28,
  parameter int unsigned TIMEOUT     = TICK_TIMEOUT_DEFAULT,
  parameter int unsigned BEAT_W      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                slow_in,
  input  logic                enable,
  input  logic                clear_beat,
  output logic                tick_rise,
  output logic                tick_fall,
  output logic [BEAT_W-1:0]   beat,
  output logic [PERIOD_W-1:0] period,
  output logic                locked,
  output logic                stalled
);

  localparam logic [PERIOD_W-1:0] TIMEOUT_C = PERIOD_W'(TIMEOUT);
  // The counter is one behind the elapsed distance, so stall one count early.
  localparam logic [PERIOD_W-1:0] STALL_AT  = PERIOD_W'(TIMEOUT - 1);

  logic                rise_s;
  logic                fall_s;
  logic                rise_en;
  logic                timeout_hit;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] cnt_inc;
  logic [PERIOD_W-1:0] cnt_sat;
  sync_state_e         state;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .async_in(slow_in),
    .rise    (rise_s),
    .fall    (fall_s)
  );

  assign rise_en     = rise_s & enable;
  assign cnt_inc     = cnt + PERIOD_W'(1);
  assign cnt_sat     = (cnt == TIMEOUT_C) ? cnt : cnt_inc;
  assign timeout_hit = (cnt >= STALL_AT);

  // Tick enables and beat counter; clear_beat beats a coincident rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_rise <= 1'b0;
      tick_fall <= 1'b0;
      beat      <= '0;
    end else begin
      tick_rise <= rise_en;
      tick_fall <= fall_s & enable;
      if (clear_beat) begin
        beat <= '0;
      end else if (rise_en) begin
        beat <= beat + BEAT_W'(1);
      end
    end
  end

  // Lock/stall FSM with interval counter and period capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      period  <= '0;
      locked  <= 1'b0;
      stalled <= 1'b0;
    end else if (!enable) begin
      state   <= IDLE;
      cnt     <= '0;
      locked  <= 1'b0;
      stalled <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rise_s) begin
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise_s) begin
            state  <= LOCKED;
            locked <= 1'b1;
            period <= cnt_inc;
            cnt    <= '0;
          end else if (timeout_hit) begin
            state   <= STALLED;
            stalled <= 1'b1;
            cnt     <= cnt_sat;
          end else begin
            cnt <= cnt_sat;
          end
        end
        LOCKED: begin
          if (rise_s) begin
            period <= cnt_inc;
            cnt    <= '0;
          end else if (timeout_hit) begin
            state   <= STALLED;
            locked  <= 1'b0;
            stalled <= 1'b1;
            cnt     <= cnt_sat;
          end else begin
            cnt <= cnt_sat;
          end
        end
        STALLED: begin
          if (rise_s) begin
            state   <= MEASURE;
            stalled <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt <= cnt_sat;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          locked  <= 1'b0;
          stalled <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_sync.sv
// Directed bench for tick_sync: latency, lock, stall/recover, beat clear,
// enable gating and asynchronous reset.
module tb_tick_sync;

  localparam int unsigned PERIOD_W = 28;
  localparam int unsigned BEAT_W   = 2;

  logic                clk;
  logic                reset;
  logic                slow_in;
  logic                enable;
  logic                clear_beat;
  logic                tick_rise;
  logic                tick_fall;
  logic [BEAT_W-1:0]   beat;
  logic [PERIOD_W-1:0] period;
  logic                locked;
  logic                stalled;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int base = 0;
  int nr = 0;
  int first_fall = -1;
  int dbl = 0;
  bit prev_tr = 1'b0;
  int cyc_log[32];
  int beat_log[32];
  int per_log[32];
  int lock_log[32];
  int stl_log[32];

  tick_sync #(
    .SYNC_STAGES(2),
    .PERIOD_W   (PERIOD_W),
    .TIMEOUT    (20),
    .BEAT_W     (BEAT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .slow_in   (slow_in),
    .enable    (enable),
    .clear_beat(clear_beat),
    .tick_rise (tick_rise),
    .tick_fall (tick_fall),
    .beat      (beat),
    .period    (period),
    .locked    (locked),
    .stalled   (stalled)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Log every tick_rise together with the outputs updated on that edge.
  always @(negedge clk) begin
    if (tick_rise && nr < 32) begin
      cyc_log[nr]  = cyc;
      beat_log[nr] = int'(beat);
      per_log[nr]  = int'(period);
      lock_log[nr] = int'(locked);
      stl_log[nr]  = int'(stalled);
      nr = nr + 1;
    end
    if (tick_rise && prev_tr) dbl = dbl + 1;
    prev_tr = tick_rise;
    if (tick_fall && first_fall < 0) first_fall = cyc;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rise_cycle(input int per);
    slow_in = 1'b1;
    repeat (per / 2) step();
    slow_in = 1'b0;
    repeat (per - per / 2) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tick_rise"}, int'(tick_rise), 0);
    check({tag, "_tick_fall"}, int'(tick_fall), 0);
    check({tag, "_beat"},      int'(beat),      0);
    check({tag, "_period"},    int'(period),    0);
    check({tag, "_locked"},    int'(locked),    0);
    check({tag, "_stalled"},   int'(stalled),   0);
  endtask

  initial begin
    reset      = 1'b1;
    slow_in    = 1'b0;
    enable     = 1'b1;
    clear_beat = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    base  = cyc;
    check_all_zero("rst");

    // Latency: slow_in high first sampled at P1, tick after P4.
    slow_in = 1'b1;
    repeat (3) step();
    check("lat_early", int'(tick_rise), 0);
    step();
    check("lat_rise",   int'(tick_rise), 1);
    check("lat_beat",   int'(beat),      1);
    check("lat_locked", int'(locked),    0);
    check("lat_period", int'(period),    0);
    step();
    check("lat_width", int'(tick_rise), 0);

    // Lock: rises every 8 cycles, ticks at P4, P12 ... P44.
    slow_in = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 5; i++) rise_cycle(8);
    check("fall_lat",  first_fall - base, 9);
    check("lock_nr",   nr, 6);
    check("lock_gap",  cyc_log[1] - cyc_log[0], 8);
    check("lock_l0",   lock_log[0], 0);
    check("lock_l1",   lock_log[1], 1);
    check("lock_per",  per_log[1], 8);
    check("beat_0",    beat_log[0], 1);
    check("beat_1",    beat_log[1], 2);
    check("beat_2",    beat_log[2], 3);
    check("beat_3",    beat_log[3], 0);
    check("beat_4",    beat_log[4], 1);
    check("lock_t5",   cyc_log[5] - base, 44);

    // Stall: last tick at P44, stalled on P64.
    while (cyc - base < 63) step();
    check("pre_stall_s", int'(stalled), 0);
    check("pre_stall_l", int'(locked),  1);
    step();
    check("stall_s",   int'(stalled), 1);
    check("stall_l",   int'(locked),  0);
    check("stall_per", int'(period),  8);

    // Recover at period 6: ticks P68 (MEASURE), P74 (LOCKED), P80, P86.
    for (int i = 0; i < 4; i++) rise_cycle(6);
    check("rec_l6",    lock_log[6], 0);
    check("rec_s6",    stl_log[6], 0);
    check("rec_hold",  per_log[6], 8);
    check("rec_b6",    beat_log[6], 3);
    check("rec_l7",    lock_log[7], 1);
    check("rec_per",   per_log[7], 6);
    check("rec_b9",    beat_log[9], 2);

    // Clear collides with the P92 tick while beat is 2.
    slow_in = 1'b1;
    repeat (3) step();
    clear_beat = 1'b1;
    step();
    check("clr_tick", int'(tick_rise), 1);
    check("clr_beat", int'(beat),      0);
    clear_beat = 1'b0;
    slow_in    = 1'b0;
    repeat (2) step();

    // Enable: one more tick (beat 1), then rises while disabled are ignored.
    rise_cycle(6);
    enable = 1'b0;
    rise_cycle(6);
    rise_cycle(6);
    check("en_nr",     nr, 12);
    check("en_locked", int'(locked),  0);
    check("en_stall",  int'(stalled), 0);
    check("en_beat",   int'(beat),    1);
    check("en_period", int'(period),  6);
    enable = 1'b1;
    rise_cycle(6);
    rise_cycle(6);
    check("reen_nr",  nr, 14);
    check("reen_l12", lock_log[12], 0);
    check("reen_l13", lock_log[13], 1);
    check("reen_per", per_log[13], 6);
    check("reen_b13", beat_log[13], 3);
    check("reen_locked", int'(locked), 1);

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("arst");
    check("single_pulse", dbl, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
